// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core-side request/response and RAM-side strobe signals of the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority fetch/data arbiter onto a single-ported RAM with bounded fetch starvation
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    localparam int starve_w = $clog2(STARVE_MAX + 1);
    localparam logic [starve_w-1:0] starve_top = starve_w'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

    state_t              state, state_nx;
    logic [starve_w-1:0] starve;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                dreq;
    logic                starved;
    logic                busy;

    assign dreq    = bus.dREN | bus.dWEN;
    assign starved = bus.iREN & (starve == starve_top);
    assign busy    = state != IDLE;

    // data wins in IDLE unless the fetch has waited out its starvation budget; grants end on ramready
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = (dreq & ~starved) ? DGNT : bus.iREN ? IGNT : IDLE;
        else if (bus.ramready) state_nx = IDLE;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nx;
    end

    // capture the winner's operation, address and store data so later request changes are ignored
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_wr  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && state_nx == DGNT) begin
            op_wr  <= bus.dWEN;
            addr_q <= bus.daddr;
            data_q <= bus.dstore;
        end else if (state == IDLE && state_nx == IGNT) begin
            op_wr  <= 1'b0;
            addr_q <= bus.iaddr;
            data_q <= '0;
        end
    end

    // count data completions that overtook a waiting fetch; reset once the fetch is served or withdrawn
    always_ff @(posedge CLK) begin
        if (RST || !bus.iREN || (state == IGNT && bus.ramready)) starve <= '0;
        else if (state == DGNT && bus.ramready && starve != starve_top) starve <= starve + starve_w'(1);
    end

    assign bus.ramREN   = busy & ~op_wr;
    assign bus.ramWEN   = busy & op_wr;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = data_q;
    assign bus.iwait    = bus.iREN & ~(state == IGNT & bus.ramready);
    assign bus.dwait    = dreq & ~(state == DGNT & bus.ramready);
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable RAM responder
module tb_mem_arbiter;
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic clk;
    logic rst;
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    acc_t        exp_q[$];
    bit          order[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat     = 1;
    int          gcnt    = 0;
    bit          rdy_force = 0;
    bit          keep    = 0;
    bit          i_done, d_done;
    logic [31:0] last_iload;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ramfun(logic [31:0] a);
        return a ^ 32'hDEADBEAF;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(logic wr, logic [31:0] addr, logic [31:0] data);
        acc_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic mon();
        acc_t e;
        i_done = 0;
        d_done = 0;
        if (bus.ramREN | bus.ramWEN) chk("strobe_excl", bus.ramREN & bus.ramWEN, 0);
        if ((bus.ramREN | bus.ramWEN) & bus.ramready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_access", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("ram_wr", bus.ramWEN, e.wr);
                chk("ram_addr", bus.ramaddr, e.addr);
                if (e.wr) chk("ram_store", bus.ramstore, e.data);
            end
        end
        if (bus.iREN & ~bus.iwait) begin
            chk("iload", bus.iload, ramfun(bus.iaddr));
            last_iload = bus.iload;
            i_done = 1;
            order.push_back(1);
            if (!keep) bus.iREN = 0;
        end
        if ((bus.dREN | bus.dWEN) & ~bus.dwait) begin
            if (bus.dREN & ~bus.dWEN) chk("dload", bus.dload, ramfun(bus.daddr));
            d_done = 1;
            order.push_back(0);
            if (!keep) begin
                bus.dREN = 0;
                bus.dWEN = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        gcnt = (bus.ramREN | bus.ramWEN) ? gcnt + 1 : 0;
        bus.ramready = rdy_force | (gcnt != 0 && gcnt >= lat);
        bus.ramload  = ramfun(bus.ramaddr);
        #1;
        mon();
    endtask

    initial begin
        int td, ti;
        bit prev_i;
        bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramready = 0;
        rst = 1;
        bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'h55;
        cyc();
        cyc();
        chk("t1_rst_wen", bus.ramWEN, 0);
        chk("t1_rst_ren", bus.ramREN, 0);
        chk("t1_rst_addr", bus.ramaddr, 0);
        chk("t1_rst_dwait", bus.dwait, 1);
        chk("t1_rst_starve", dut.starve, 0);
        rst = 0;
        lat = 1;
        push(1, 32'h80, 32'h55);
        cyc();
        chk("t1_dgnt_wen", bus.ramWEN, 1);
        chk("t1_dgnt_done", d_done, 1);
        cyc();
        chk("t1_idle_wen", bus.ramWEN, 0);

        lat = 3;
        bus.iREN = 1; bus.iaddr = 32'h40;
        push(0, 32'h40, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("t2_ren", bus.ramREN, 1);
            chk("t2_addr", bus.ramaddr, 32'h40);
            chk("t2_done", i_done, k == 3);
        end
        chk("t2_iload", last_iload, 32'hDEADBEEF);
        cyc();
        chk("t2_idle_ren", bus.ramREN, 0);
        chk("t2_idle_wen", bus.ramWEN, 0);

        lat = 1;
        td = -1; ti = -1;
        bus.iREN = 1; bus.iaddr = 32'h100;
        bus.dREN = 1; bus.daddr = 32'h200;
        push(0, 32'h200, 0);
        push(0, 32'h100, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 1) chk("t3_first_addr", bus.ramaddr, 32'h200);
            if (d_done && td < 0) td = k;
            if (i_done && ti < 0) ti = k;
        end
        chk("t3_data_first", 64'(td), 1);
        chk("t3_gap", 64'(ti - td), 2);
        chk("t3_starve", dut.starve, 0);

        order.delete();
        keep = 1; prev_i = 0;
        bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h77;
        bus.iREN = 1; bus.iaddr = 32'h44;
        for (int k = 0; k < 4; k++) push(1, 32'h300, 32'h77);
        push(0, 32'h44, 0);
        for (int k = 0; k < 3; k++) push(1, 32'h300, 32'h77);
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (prev_i) chk("t4_starve_clr", dut.starve, 0);
            prev_i = i_done;
            if (order.size() >= 8) break;
        end
        keep = 0;
        bus.dWEN = 0; bus.iREN = 0;
        chk("t4_count", order.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < order.size()) chk("t4_order", order[k], k == 4);
        cyc();

        lat = 3;
        bus.dREN = 1; bus.daddr = 32'h500;
        push(0, 32'h500, 0);
        cyc();
        chk("t5_abort_ren1", bus.ramREN, 1);
        bus.dREN = 0;
        cyc();
        chk("t5_abort_ren2", bus.ramREN, 1);
        chk("t5_abort_addr", bus.ramaddr, 32'h500);
        cyc();
        chk("t5_abort_ren3", bus.ramREN, 1);
        chk("t5_abort_nodone", d_done, 0);
        cyc();
        chk("t5_abort_idle", bus.ramREN | bus.ramWEN, 0);

        lat = 5;
        bus.iREN = 1; bus.iaddr = 32'h600;
        cyc();
        chk("t5_ignt_ren", bus.ramREN, 1);
        cyc();
        rst = 1;
        bus.iREN = 0;
        cyc();
        chk("t5_rst_ren", bus.ramREN, 0);
        chk("t5_rst_addr", bus.ramaddr, 0);
        rst = 0;

        rdy_force = 1;
        cyc();
        cyc();
        chk("t5_idle_rdy", bus.ramREN | bus.ramWEN, 0);
        rdy_force = 0;

        lat = 2;
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h700; bus.dstore = 32'h1234;
        push(1, 32'h700, 32'h1234);
        cyc();
        chk("t6_wen", bus.ramWEN, 1);
        chk("t6_ren", bus.ramREN, 0);
        chk("t6_store", bus.ramstore, 32'h1234);
        bus.daddr = 32'h999; bus.dstore = 32'hFFFF;
        cyc();
        chk("t6_done", d_done, 1);
        chk("t6_hold_addr", bus.ramaddr, 32'h700);
        cyc();

        chk("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
